// File: rtl/simple_uart_tx_if.sv
// Bus device-side signals for simple_uart_tx.
// master: drives req_i/we_i/be_i/addr_i/wdata_i, receives rvalid_o/rdata_o/err_o.
// slave : the UART side of the same bundle.
interface simple_uart_tx_if #(
   parameter int unsigned AddressWidth = 32
);
   logic                    req_i;
   logic                    we_i;
   logic [3:0]              be_i;
   logic [AddressWidth-1:0] addr_i;
   logic [31:0]             wdata_i;
   logic                    rvalid_o;
   logic [31:0]             rdata_o;
   logic                    err_o;

   modport master (
      output req_i, we_i, be_i, addr_i, wdata_i,
      input  rvalid_o, rdata_o, err_o
   );

   modport slave (
      input  req_i, we_i, be_i, addr_i, wdata_i,
      output rvalid_o, rdata_o, err_o
   );
endinterface

// File: rtl/simple_uart_tx.sv
// Memory-mapped UART transmitter: bytes written to TXDATA go through a TX FIFO
// and are serialised onto tx_o as 8N1 frames, DIV clocks per bit.
// Ports:
//   clk_i  - system clock
//   rst_i  - synchronous reset, active-high
//   bus    - device-side bus (simple_uart_tx_if.slave), response 1 cycle after req
//   tx_o   - serial line, idle high
//   irq_o  - level interrupt: irq_en & FIFO empty & shifter idle (registered)
// Optional feature macro: SIMPLE_UART_TX_PARITY_EN adds an even-parity bit
// between data and stop (8E1) and sets STATUS[12].
module simple_uart_tx #(
   parameter int unsigned FifoDepth    = 8,
   parameter logic [15:0] DivResetVal  = 16'd868,
   parameter int unsigned AddressWidth = 32
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   simple_uart_tx_if.slave        bus,
   output logic                   tx_o,
   output logic                   irq_o
);
   localparam int unsigned PtrW = $clog2(FifoDepth) + 1;
   localparam int unsigned IdxW = PtrW - 1;

`ifdef SIMPLE_UART_TX_PARITY_EN
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
   localparam logic ParityEn = 1'b1;
`else
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
   localparam logic ParityEn = 1'b0;
`endif

   state_t            r_state;
   logic              r_tx;
   logic [7:0]        r_shift;
   logic [15:0]       r_limit;
   logic [15:0]       r_timer;
   logic [2:0]        r_bit;
`ifdef SIMPLE_UART_TX_PARITY_EN
   logic              r_par;
`endif
   logic [7:0]        r_mem [FifoDepth];
   logic [PtrW-1:0]   r_wptr;
   logic [PtrW-1:0]   r_rptr;
   logic [15:0]       r_div;
   logic [1:0]        r_ctrl;
   logic              r_ovf;
   logic              r_irq;
   logic              r_rvalid;
   logic              r_err;
   logic [31:0]       r_rdata;

   logic [7:0]        w_off;
   logic              w_off_ok;
   logic              w_wr;
   logic              w_txd_wr;
   logic              w_push;
   logic [PtrW-1:0]   w_level;
   logic              w_full;
   logic              w_empty;
   logic              w_busy;
   logic              w_bit_end;
   logic              w_pop;
   logic [7:0]        w_head;
   logic [15:0]       w_limit;
   logic [31:0]       w_status;
   logic [31:0]       w_rdata;
   logic              w_unused;

   assign w_off     = bus.addr_i[9:2];
   assign w_off_ok  = (w_off < 8'd4);
   assign w_wr      = bus.req_i & bus.we_i & w_off_ok;
   assign w_txd_wr  = w_wr & (w_off == 8'd0) & bus.be_i[0];
   // A push is judged against the current fill level, so a same-cycle pop never rescues a full FIFO.
   assign w_push    = w_txd_wr & ~w_full;
   assign w_level   = r_wptr - r_rptr;
   assign w_full    = (w_level == PtrW'(FifoDepth));
   assign w_empty   = (r_wptr == r_rptr);
   assign w_busy    = (r_state != S_IDLE);
   assign w_bit_end = (r_timer == r_limit - 16'd1);
   assign w_head    = r_mem[r_rptr[IdxW-1:0]];
   assign w_limit   = (r_div == 16'd0) ? 16'd1 : r_div;
   // Pop from IDLE, or straight out of the last STOP cycle so frames abut.
   assign w_pop     = r_ctrl[0] & ~w_empty &
                      ((r_state == S_IDLE) | ((r_state == S_STOP) & w_bit_end));
   assign w_status  = {19'd0, ParityEn, 4'(w_level), 4'd0, r_ovf, w_busy, w_empty, w_full};
   assign w_unused  = ^{bus.addr_i[1:0], bus.addr_i[AddressWidth-1:10],
                        bus.wdata_i[31:16], bus.be_i[3:2]};

   // Register read mux
   always_comb begin
      w_rdata = 32'd0;
      case (w_off)
         8'd1:    w_rdata = w_status;
         8'd2:    w_rdata = {16'd0, r_div};
         8'd3:    w_rdata = {30'd0, r_ctrl};
         default: w_rdata = 32'd0;
      endcase
   end

   // FIFO storage; pointers alone define contents, so no reset needed
   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_mem[r_wptr[IdxW-1:0]] <= bus.wdata_i[7:0];
      end
   end

   // Bus response, control registers, write pointer and interrupt
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_rvalid <= 1'b0;
         r_err    <= 1'b0;
         r_rdata  <= 32'd0;
         r_wptr   <= '0;
         r_ovf    <= 1'b0;
         r_div    <= DivResetVal;
         r_ctrl   <= 2'd0;
         r_irq    <= 1'b0;
      end else begin
         r_rvalid <= bus.req_i;
         r_err    <= bus.req_i & ~w_off_ok;
         r_rdata  <= (bus.req_i & ~bus.we_i & w_off_ok) ? w_rdata : 32'd0;
         r_irq    <= r_ctrl[1] & w_empty & ~w_busy;
         if (w_push) begin
            r_wptr <= r_wptr + PtrW'(1);
         end
         if (w_txd_wr & w_full) begin
            r_ovf <= 1'b1;
         end else if (w_wr & (w_off == 8'd1) & bus.be_i[0] & bus.wdata_i[3]) begin
            r_ovf <= 1'b0;
         end
         if (w_wr & (w_off == 8'd2)) begin
            if (bus.be_i[0]) r_div[7:0]  <= bus.wdata_i[7:0];
            if (bus.be_i[1]) r_div[15:8] <= bus.wdata_i[15:8];
         end
         if (w_wr & (w_off == 8'd3) & bus.be_i[0]) begin
            r_ctrl <= bus.wdata_i[1:0];
         end
      end
   end

   // Baud FSM: each state lasts r_limit clocks; r_tx is set on the edge that enters a bit
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= S_IDLE;
         r_tx    <= 1'b1;
         r_rptr  <= '0;
         r_shift <= 8'd0;
         r_limit <= 16'd1;
         r_timer <= 16'd0;
         r_bit   <= 3'd0;
`ifdef SIMPLE_UART_TX_PARITY_EN
         r_par   <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_pop) begin
                  r_state <= S_START;
                  r_tx    <= 1'b0;
                  r_shift <= w_head;
                  r_limit <= w_limit;
                  r_timer <= 16'd0;
                  r_rptr  <= r_rptr + PtrW'(1);
`ifdef SIMPLE_UART_TX_PARITY_EN
                  r_par   <= ^w_head;
`endif
               end
            end
            S_START: begin
               if (w_bit_end) begin
                  r_state <= S_DATA;
                  r_timer <= 16'd0;
                  r_bit   <= 3'd0;
                  r_tx    <= r_shift[0];
                  r_shift <= r_shift >> 1;
               end else begin
                  r_timer <= r_timer + 16'd1;
               end
            end
            S_DATA: begin
               if (w_bit_end) begin
                  r_timer <= 16'd0;
                  if (r_bit == 3'd7) begin
`ifdef SIMPLE_UART_TX_PARITY_EN
                     r_state <= S_PARITY;
                     r_tx    <= r_par;
`else
                     r_state <= S_STOP;
                     r_tx    <= 1'b1;
`endif
                  end else begin
                     r_bit   <= r_bit + 3'd1;
                     r_tx    <= r_shift[0];
                     r_shift <= r_shift >> 1;
                  end
               end else begin
                  r_timer <= r_timer + 16'd1;
               end
            end
`ifdef SIMPLE_UART_TX_PARITY_EN
            S_PARITY: begin
               if (w_bit_end) begin
                  r_state <= S_STOP;
                  r_timer <= 16'd0;
                  r_tx    <= 1'b1;
               end else begin
                  r_timer <= r_timer + 16'd1;
               end
            end
`endif
            S_STOP: begin
               if (w_bit_end) begin
                  r_timer <= 16'd0;
                  if (w_pop) begin
                     r_state <= S_START;
                     r_tx    <= 1'b0;
                     r_shift <= w_head;
                     r_limit <= w_limit;
                     r_rptr  <= r_rptr + PtrW'(1);
`ifdef SIMPLE_UART_TX_PARITY_EN
                     r_par   <= ^w_head;
`endif
                  end else begin
                     r_state <= S_IDLE;
                  end
               end else begin
                  r_timer <= r_timer + 16'd1;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_tx    <= 1'b1;
            end
         endcase
      end
   end

   assign tx_o         = r_tx;
   assign irq_o        = r_irq;
   assign bus.rvalid_o = r_rvalid;
   assign bus.rdata_o  = r_rdata;
   assign bus.err_o    = r_err;
endmodule
